poly_mul_sched: RTL and testbench

Sequencer for the tiled polynomial multiplier (poly_mult_top) in the ciphertext-multiply path. On one start it issues the four ciphertext cross products in the fixed order c11, c01, c10, c00. This matches the c2 -> c1_1 -> c1_0 -> c0 order the downstream reconstruction/poly_mod routing expects. For each product it clears the multiplier, streams every A/B tile pair, and waits for the multiplier's done before moving on.

---
 rtl/he_sched_pkg.sv | 37 +++
 rtl/poly_mul_tile_sel.sv | 32 +++
 rtl/poly_mul_sched.sv | 184 ++++++++++++++++++
 tb/tb_poly_mul_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/he_sched_pkg.sv
// Shared types for the ciphertext-multiply schedulers.
//   sched_state_e : sequencer states
//   prod_e        : cross-product id, encoded as {a_sel, b_sel}
//   next_prod     : issue order c11 -> c01 -> c10 -> c00
package he_sched_pkg;

    localparam int unsigned PERF_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } sched_state_e;

    typedef enum logic [1:0] {
        P_C00 = 2'd0,
        P_C01 = 2'd1,
        P_C10 = 2'd2,
        P_C11 = 2'd3
    } prod_e;

    // Order matches the c2 -> c1_1 -> c1_0 -> c0 routing downstream.
    function automatic prod_e next_prod(input prod_e p);
        prod_e r;
        case (p)
            P_C11:   r = P_C01;
            P_C01:   r = P_C10;
            P_C10:   r = P_C00;
            default: r = P_C00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/poly_mul_tile_sel.sv
// Combinational selector of one TILE_N-coefficient tile.
//   ct     : two polynomials of DEGREE_N coefficients
//   sel    : which polynomial (0/1)
//   idx    : tile index within the polynomial
//   tile   : coefficients idx*TILE_N .. idx*TILE_N+TILE_N-1
module poly_mul_tile_sel #(
    parameter int unsigned DEGREE_N  = 16,
    parameter int unsigned TILE_N    = 4,
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0] ct,
    input  logic                                    sel,
    input  logic [IDX_W-1:0]                        idx,
    output logic [TILE_N-1:0][BIT_WIDTH-1:0]        tile
);

    localparam int unsigned COEF_W = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;

    logic [COEF_W-1:0] base;

    assign base = COEF_W'(idx) * COEF_W'(TILE_N);

    // Gather the tile coefficient by coefficient.
    always_comb begin
        tile = '0;
        for (int j = 0; j < int'(TILE_N); j++) begin
            tile[j] = ct[sel][base + COEF_W'(j)];
        end
    end

endmodule

// File: rtl/poly_mul_sched.sv
// Sequencer for the tiled polynomial multiplier. One start issues the four
// cross products c11, c01, c10, c00; each is cleared, fed with all NT*NT
// tile pairs (A outer, B inner) and drained until the multiplier's done.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start_i           : begin a sequence (sampled only in IDLE)
//   ct_a_i, ct_b_i    : operand ciphertexts, stable while busy
//   mul_ready_i       : multiplier can take a tile pair
//   mul_done_i        : multiplier finished the current product
//   mul_start_o       : tile pair valid
//   mul_rst_n_o       : active-low multiplier clear
//   tile_a_o/tile_b_o : current A/B tile
//   prod_idx_o        : current product {a_sel, b_sel}
//   busy_o, done_o    : sequence active / one-cycle completion pulse
//   err_o             : sticky early-done protocol error
//   perf_cycles_o     : busy cycles   (POLY_MUL_SCHED_PERF_EN, else 0)
//   perf_stall_o      : FEED stalls   (POLY_MUL_SCHED_PERF_EN, else 0)
module poly_mul_sched
    import he_sched_pkg::*;
#(
    parameter int unsigned DEGREE_N  = 16,
    parameter int unsigned TILE_N    = 4,
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start_i,
    input  logic [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0] ct_a_i,
    input  logic [1:0][DEGREE_N-1:0][BIT_WIDTH-1:0] ct_b_i,
    input  logic                                    mul_ready_i,
    input  logic                                    mul_done_i,
    output logic                                    mul_start_o,
    output logic                                    mul_rst_n_o,
    output logic [TILE_N-1:0][BIT_WIDTH-1:0]        tile_a_o,
    output logic [TILE_N-1:0][BIT_WIDTH-1:0]        tile_b_o,
    output logic [1:0]                              prod_idx_o,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    err_o,
    output logic [PERF_W-1:0]                       perf_cycles_o,
    output logic [PERF_W-1:0]                       perf_stall_o
);

    localparam int unsigned NT    = DEGREE_N / TILE_N;
    localparam int unsigned IDX_W = (NT > 1) ? $clog2(NT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NT - 1);

    sched_state_e     state, state_n;
    prod_e            prod, prod_n;
    logic [IDX_W-1:0] ia, ia_n, ib, ib_n;
    logic             err_n;
    logic             xfer;
    logic             start_acc;

    assign xfer       = mul_start_o & mul_ready_i;
    assign start_acc  = (state == IDLE) & start_i;
    assign prod_idx_o = prod;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            prod        <= P_C11;
            ia          <= '0;
            ib          <= '0;
            err_o       <= 1'b0;
            mul_start_o <= 1'b0;
            mul_rst_n_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_n;
            prod        <= prod_n;
            ia          <= ia_n;
            ib          <= ib_n;
            err_o       <= err_n;
            mul_start_o <= (state_n == FEED);
            mul_rst_n_o <= (state_n != CLEAR);
            busy_o      <= (state_n != IDLE);
            done_o      <= (state_n == DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        prod_n  = prod;
        ia_n    = ia;
        ib_n    = ib;
        err_n   = err_o;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = CLEAR;
                    prod_n  = P_C11;
                    ia_n    = '0;
                    ib_n    = '0;
                end
            end
            CLEAR: state_n = FEED;
            FEED: begin
                // Done before the last pair was handed over is a protocol error.
                if (mul_done_i) err_n = 1'b1;
                if (xfer) begin
                    if (ib == LAST_IDX) begin
                        ib_n = '0;
                        if (ia == LAST_IDX) begin
                            ia_n    = '0;
                            state_n = DRAIN;
                        end else begin
                            ia_n = ia + IDX_W'(1);
                        end
                    end else begin
                        ib_n = ib + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (mul_done_i) state_n = NEXT;
            end
            NEXT: begin
                ia_n = '0;
                ib_n = '0;
                if (prod == P_C00) begin
                    state_n = DONE;
                end else begin
                    prod_n  = next_prod(prod);
                    state_n = CLEAR;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    poly_mul_tile_sel #(
        .DEGREE_N  (DEGREE_N),
        .TILE_N    (TILE_N),
        .BIT_WIDTH (BIT_WIDTH),
        .IDX_W     (IDX_W)
    ) u_sel_a (
        .ct   (ct_a_i),
        .sel  (prod[1]),
        .idx  (ia),
        .tile (tile_a_o)
    );

    poly_mul_tile_sel #(
        .DEGREE_N  (DEGREE_N),
        .TILE_N    (TILE_N),
        .BIT_WIDTH (BIT_WIDTH),
        .IDX_W     (IDX_W)
    ) u_sel_b (
        .ct   (ct_b_i),
        .sel  (prod[0]),
        .idx  (ib),
        .tile (tile_b_o)
    );

`ifdef POLY_MUL_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_cycles, perf_stall;

    // Saturating counters, cleared on reset and on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst || start_acc) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy_o && (perf_cycles != '1)) perf_cycles <= perf_cycles + PERF_W'(1);
            if ((state == FEED) && !mul_ready_i && (perf_stall != '1))
                perf_stall <= perf_stall + PERF_W'(1);
        end
    end

    assign perf_cycles_o = perf_cycles;
    assign perf_stall_o  = perf_stall;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign perf_cycles_o    = '0;
    assign perf_stall_o     = '0;
`endif

endmodule

// File: tb/tb_poly_mul_sched.sv
// Directed bench for poly_mul_sched (DEGREE_N=16, TILE_N=4).
module tb_poly_mul_sched;

    localparam int unsigned DEG = 16;
    localparam int unsigned TN  = 4;
    localparam int unsigned BW  = 32;
    localparam int          NTL = DEG / TN;

    typedef logic [TN-1:0][BW-1:0] tile_t;

    logic                          clk;
    logic                          rst;
    logic                          start_i;
    logic [1:0][DEG-1:0][BW-1:0]   ct_a, ct_b;
    logic                          mul_ready_i, mul_done_i;
    logic                          mul_start_o, mul_rst_n_o;
    tile_t                         tile_a_o, tile_b_o;
    logic [1:0]                    prod_idx_o;
    logic                          busy_o, done_o, err_o;
    logic [31:0]                   perf_cycles_o, perf_stall_o;

    int checks = 0;
    int errors = 0;
    int xfers, feed, stalls, ncyc;
    int order [4] = '{3, 1, 2, 0};

    poly_mul_sched #(.DEGREE_N(DEG), .TILE_N(TN), .BIT_WIDTH(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .ct_a_i        (ct_a),
        .ct_b_i        (ct_b),
        .mul_ready_i   (mul_ready_i),
        .mul_done_i    (mul_done_i),
        .mul_start_o   (mul_start_o),
        .mul_rst_n_o   (mul_rst_n_o),
        .tile_a_o      (tile_a_o),
        .tile_b_o      (tile_b_o),
        .prod_idx_o    (prod_idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .perf_cycles_o (perf_cycles_o),
        .perf_stall_o  (perf_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_t(input string tag, input tile_t obs, input tile_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic tile_t mk_tile(input int base);
        tile_t t;
        for (int j = 0; j < int'(TN); j++) t[j] = BW'(base + j);
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence from IDLE acting as the multiplier.
    // rmode 0: ready always high; 1: ready alternates 0/1 over FEED cycles.
    // d: done delay after last pair; early_at: pulse done after that many pairs;
    // abort_at: return right after that many pairs; inj: start pulses in DRAIN.
    task automatic run_seq(input int rmode, input int d, input int early_at,
                           input int abort_at, input bit inj);
        int  cd, fcnt, t, p;
        bit  early_pend, stall_prev, finished;
        xfers = 0; feed = 0; stalls = 0; ncyc = 0;
        cd = -1; fcnt = 0; early_pend = 0; stall_prev = 0; finished = 0;
        start_i = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            step();
            ncyc++;
            start_i    = 1'b0;
            mul_done_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mul_done_i = 1'b1;
                    cd = -1;
                end
            end
            if (early_pend) begin
                mul_done_i = 1'b1;
                early_pend = 0;
            end
            if (inj && cd == 1) start_i = 1'b1;
            if (ncyc == 1) begin
                chk("clear_rst_n", 32'(mul_rst_n_o), 32'd0);
                chk("clear_busy", 32'(busy_o), 32'd1);
                chk("clear_prod", 32'(prod_idx_o), 32'd3);
            end
            if (stall_prev) chk("stall_hold", 32'(mul_start_o), 32'd1);
            stall_prev = 0;
            mul_ready_i = 1'b1;
            if (mul_start_o) begin
                if (rmode == 1) mul_ready_i = ((fcnt % 2) == 1);
                fcnt++;
                feed++;
                if (mul_ready_i) begin
                    if (xfers < 64) begin
                        t = xfers % (NTL * NTL);
                        p = order[xfers / (NTL * NTL)];
                        chk("xfer_prod", 32'(prod_idx_o), 32'(p));
                        chk_t("xfer_tile_a", tile_a_o,
                              mk_tile((p / 2) * int'(DEG) + (t / NTL) * int'(TN)));
                        chk_t("xfer_tile_b", tile_b_o,
                              mk_tile(100 + (p % 2) * int'(DEG) + (t % NTL) * int'(TN)));
                        if (xfers == 21) begin
                            chk_t("c01_x5_a", tile_a_o, mk_tile(4));
                            chk_t("c01_x5_b", tile_b_o, mk_tile(120));
                        end
                        if (t == NTL * NTL - 1) begin
                            cd = d;
                            fcnt = 0;
                        end
                    end else begin
                        chk("extra_xfer", 32'(xfers), 32'd63);
                    end
                    xfers++;
                    if (xfers == early_at) early_pend = 1;
                end else begin
                    stalls++;
                    stall_prev = 1;
                end
            end
            if (abort_at != 0 && xfers == abort_at) begin
                finished = 1;
                break;
            end
            if (done_o) begin
                finished = 1;
                break;
            end
        end
        chk("run_finished", 32'(finished), 32'd1);
    endtask

    initial begin
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < int'(DEG); k++) begin
                ct_a[p][k] = BW'(p * int'(DEG) + k);
                ct_b[p][k] = BW'(100 + p * int'(DEG) + k);
            end
        rst = 1'b0; start_i = 1'b0; mul_ready_i = 1'b0; mul_done_i = 1'b0;
        step();
        step();
        chk("rst_start", 32'(mul_start_o), 32'd0);
        chk("rst_rst_n", 32'(mul_rst_n_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_prod", 32'(prod_idx_o), 32'd3);
        chk_t("rst_tile_a", tile_a_o, mk_tile(16));
        chk_t("rst_tile_b", tile_b_o, mk_tile(116));
        chk("rst_perf_c", perf_cycles_o, 32'd0);
        chk("rst_perf_s", perf_stall_o, 32'd0);

        rst = 1'b1;
        step();
        chk("idle_rst_n", 32'(mul_rst_n_o), 32'd1);
        mul_done_i = 1'b1;
        step();
        mul_done_i = 1'b0;
        step();
        chk("idle_done_err", 32'(err_o), 32'd0);
        chk("idle_done_busy", 32'(busy_o), 32'd0);

        // Nominal run.
        run_seq(0, 3, 0, 0, 0);
        chk("nom_cycles", 32'(ncyc), 32'd85);
        chk("nom_xfers", 32'(xfers), 32'd64);
        chk("nom_feed", 32'(feed), 32'd64);
        chk("nom_err", 32'(err_o), 32'd0);
        step();
        chk("nom_idle_busy", 32'(busy_o), 32'd0);
        chk("nom_idle_done", 32'(done_o), 32'd0);
`ifdef POLY_MUL_SCHED_PERF_EN
        chk("nom_perf_c", perf_cycles_o, 32'd85);
        chk("nom_perf_s", perf_stall_o, 32'd0);
`else
        chk("nom_perf_c", perf_cycles_o, 32'd0);
        chk("nom_perf_s", perf_stall_o, 32'd0);
`endif

        // Backpressure.
        run_seq(1, 3, 0, 0, 0);
        chk("bp_cycles", 32'(ncyc), 32'd149);
        chk("bp_xfers", 32'(xfers), 32'd64);
        chk("bp_feed", 32'(feed), 32'd128);
        chk("bp_stalls", 32'(stalls), 32'd64);
        step();
`ifdef POLY_MUL_SCHED_PERF_EN
        chk("bp_perf_c", perf_cycles_o, 32'd149);
        chk("bp_perf_s", perf_stall_o, 32'd64);
`else
        chk("bp_perf_s", perf_stall_o, 32'd0);
`endif

        // Start pulses in DRAIN and in DONE are ignored.
        run_seq(0, 3, 0, 0, 1);
        chk("inj_cycles", 32'(ncyc), 32'd85);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("inj_busy", 32'(busy_o), 32'd0);
            chk("inj_done", 32'(done_o), 32'd0);
            step();
        end

        // Early done sets a sticky error; feeding continues.
        run_seq(0, 3, 5, 0, 0);
        chk("early_cycles", 32'(ncyc), 32'd85);
        chk("early_xfers", 32'(xfers), 32'd64);
        chk("early_err", 32'(err_o), 32'd1);
        step();
        step();
        chk("early_err_sticky", 32'(err_o), 32'd1);

        // Reset in the middle of c10.
        run_seq(0, 3, 0, 36, 0);
        chk("abort_prod", 32'(prod_idx_o), 32'd2);
        rst = 1'b0;
        step();
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_rst_n", 32'(mul_rst_n_o), 32'd0);
        chk("abort_start", 32'(mul_start_o), 32'd0);
        chk("abort_err", 32'(err_o), 32'd0);
        chk("abort_prod3", 32'(prod_idx_o), 32'd3);
        chk_t("abort_tile_a", tile_a_o, mk_tile(16));
        step();
        chk("abort_rst_n_hold", 32'(mul_rst_n_o), 32'd0);
        rst = 1'b1;
        step();
        chk("abort_rel_rst_n", 32'(mul_rst_n_o), 32'd1);
        chk("abort_rel_busy", 32'(busy_o), 32'd0);
        run_seq(0, 3, 0, 0, 0);
        chk("restart_cycles", 32'(ncyc), 32'd85);
        chk("restart_xfers", 32'(xfers), 32'd64);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
